// File: rtl/sonic_scheduler.sv
// Round-robin scheduler that shares one ultrasonic ranging engine among four sensors.
// Each measurement is trigger, echo wait, echo timing, report and settle, all paced by a 1 us tick.
module sonic_scheduler #(
   parameter int TICK_DIV   = 100,
   parameter int TRIG_US    = 10,
   parameter int TIMEOUT_US = 30000,
   parameter int GAP_US     = 60000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  enable,
   input  logic [3:0]  echo,
   output logic [3:0]  trig,
   output logic [19:0] dist_out,
   output logic [1:0]  dist_id,
   output logic        dist_valid,
   output logic        timeout,
   output logic [79:0] dist_all,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, GAP} state_e;

   localparam logic [19:0] FAR_DIST = 20'hFFFFF;

   state_e            state_q, state_d;
   logic [31:0]       presc_q, presc_d;
   logic [31:0]       tick_cnt_q, tick_cnt_d;
   logic [15:0]       count_q, count_d;
   logic [1:0]        sel_q, sel_d;
   logic [19:0]       dist_out_q, dist_out_d;
   logic [1:0]        dist_id_q, dist_id_d;
   logic              dist_valid_q, dist_valid_d;
   logic              timeout_q, timeout_d;
   logic [3:0][19:0]  dist_all_q, dist_all_d;
   logic [3:0]        echo_s1_q, echo_s1_d;
   logic [3:0]        echo_s2_q, echo_s2_d;
   logic [3:0]        echo_s3_q, echo_s3_d;

   logic              tick;
   logic [3:0]        rise_vec, fall_vec;
   logic              rise, fall;
   logic              report, report_tmo;
   logic [16:0]       meas;
   logic [23:0]       prod;
   logic [19:0]       dist_new;
   logic [1:0]        next_sel, cand;
   logic              found;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves one unassigned, which would infer a latch.
      state_d      = state_q;
      count_d      = count_q;
      sel_d        = sel_q;
      dist_out_d   = dist_out_q;
      dist_id_d    = dist_id_q;
      dist_valid_d = 1'b0;
      timeout_d    = timeout_q;
      dist_all_d   = dist_all_q;
      echo_s1_d    = echo;
      echo_s2_d    = echo_s1_q;
      echo_s3_d    = echo_s2_q;
      report       = 1'b0;
      report_tmo   = 1'b0;

      tick     = (presc_q == 32'(TICK_DIV - 1));
      rise_vec = echo_s2_q & ~echo_s3_q;
      fall_vec = ~echo_s2_q & echo_s3_q;
      rise     = rise_vec[sel_q];
      fall     = fall_vec[sel_q];

      // A tick landing on the fall cycle still belongs to the echo pulse.
      meas     = {1'b0, count_q} + 17'(tick);
      prod     = 24'(meas) * 24'd17;
      dist_new = 20'(prod / 24'd1000);

      next_sel = sel_q;
      found    = 1'b0;
      cand     = sel_q;
      for (int i = 1; i <= 4; i++) begin
         cand = sel_q + 2'(i);
         if (!found && enable[cand]) begin
            next_sel = cand;
            found    = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (|enable) begin
               sel_d   = next_sel;
               state_d = TRIG;
            end
         end
         TRIG: begin
            if (tick && tick_cnt_q == 32'(TRIG_US - 1)) state_d = WAIT_RISE;
         end
         WAIT_RISE: begin
            if (rise) begin
               state_d = MEASURE;
               count_d = '0;
            end else if (tick && tick_cnt_q == 32'(TIMEOUT_US - 1)) begin
               report     = 1'b1;
               report_tmo = 1'b1;
            end
         end
         MEASURE: begin
            if (fall) begin
               report = 1'b1;
            end else if (count_q == 16'(TIMEOUT_US)) begin
               report     = 1'b1;
               report_tmo = 1'b1;
            end else if (tick) begin
               count_d = count_q + 16'd1;
            end
         end
         REPORT:  state_d = GAP;
         GAP: begin
            if (tick && tick_cnt_q == 32'(GAP_US - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Result registers load on entry to REPORT so data and strobe share the REPORT cycle.
      if (report) begin
         state_d           = REPORT;
         dist_valid_d      = 1'b1;
         dist_id_d         = sel_q;
         timeout_d         = report_tmo;
         dist_out_d        = report_tmo ? FAR_DIST : dist_new;
         dist_all_d[sel_q] = dist_out_d;
      end

      presc_d    = presc_q + 32'd1;
      tick_cnt_d = tick_cnt_q;
      if (state_d != state_q) begin
         presc_d    = '0;
         tick_cnt_d = '0;
      end else if (tick) begin
         presc_d    = '0;
         tick_cnt_d = tick_cnt_q + 32'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         presc_q      <= '0;
         tick_cnt_q   <= '0;
         count_q      <= '0;
         sel_q        <= 2'd3;
         dist_out_q   <= FAR_DIST;
         dist_id_q    <= '0;
         dist_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
         // NOTE: the per-sensor result array is reset too; its far value keeps consumers idle until real data.
         dist_all_q   <= {4{FAR_DIST}};
         echo_s1_q    <= '0;
         echo_s2_q    <= '0;
         echo_s3_q    <= '0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         tick_cnt_q   <= tick_cnt_d;
         count_q      <= count_d;
         sel_q        <= sel_d;
         dist_out_q   <= dist_out_d;
         dist_id_q    <= dist_id_d;
         dist_valid_q <= dist_valid_d;
         timeout_q    <= timeout_d;
         dist_all_q   <= dist_all_d;
         echo_s1_q    <= echo_s1_d;
         echo_s2_q    <= echo_s2_d;
         echo_s3_q    <= echo_s3_d;
      end
   end

   assign trig       = (state_q == TRIG) ? (4'b0001 << sel_q) : 4'b0000;
   assign dist_out   = dist_out_q;
   assign dist_id    = dist_id_q;
   assign dist_valid = dist_valid_q;
   assign timeout    = timeout_q;
   assign dist_all   = dist_all_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sonic_scheduler.sv
// Directed bench for sonic_scheduler with shortened timing parameters.
// Expected distances and latencies are hand-derived from the tick arithmetic.
module tb_sonic_scheduler;

   localparam int TD  = 2;
   localparam int TRG = 3;
   localparam int TMO = 5000;
   localparam int GP  = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  enable = 4'b0000;
   logic [3:0]  echo = 4'b0000;
   logic [3:0]  trig;
   logic [19:0] dist_out;
   logic [1:0]  dist_id;
   logic        dist_valid;
   logic        timeout;
   logic [79:0] dist_all;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   bit saw_trig2 = 1'b0;
   bit saw_multi = 1'b0;

   sonic_scheduler #(
      .TICK_DIV(TD), .TRIG_US(TRG), .TIMEOUT_US(TMO), .GAP_US(GP)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trig(trig),
      .dist_out(dist_out), .dist_id(dist_id), .dist_valid(dist_valid),
      .timeout(timeout), .dist_all(dist_all), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (trig[2]) saw_trig2 = 1'b1;
      if ($countones(trig) > 1) saw_multi = 1'b1;
   end

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Waits for any trigger, reports its index, edges waited and pulse width in clks.
   task automatic wait_trig(input int budget, output int idx, output int waited, output int width);
      idx = -1; waited = 0; width = 0;
      while (waited < budget && trig == 4'b0000) begin
         step(1);
         waited++;
      end
      if (trig == 4'b0000) begin
         check("trig_timeout", 80'd0, 80'd1);
         return;
      end
      for (int i = 0; i < 4; i++) if (trig[i]) idx = i;
      width = 1;
      while (width < 1000) begin
         step(1);
         if (!trig[idx]) break;
         width++;
      end
   endtask

   task automatic wait_valid(input int budget, output int edges);
      edges = 0;
      while (edges < budget) begin
         step(1);
         edges++;
         if (dist_valid) return;
      end
      check("valid_timeout", 80'd0, 80'd1);
   endtask

   // Drives an echo pulse of n_us ticks on sensor idx and checks the report that follows.
   task automatic pulse_and_check(input string tag, input int idx, input int n_us, input logic [19:0] exp_dist);
      step(3);
      echo[idx] = 1'b1;
      step(n_us * TD);
      echo[idx] = 1'b0;
      step(2);
      check({tag, "_early"}, 80'(dist_valid), 80'd0);
      step(1);
      check({tag, "_valid"}, 80'(dist_valid), 80'd1);
      check({tag, "_dist"}, 80'(dist_out), 80'(exp_dist));
      check({tag, "_id"}, 80'(dist_id), 80'(idx));
      check({tag, "_tmo"}, 80'(timeout), 80'd0);
      check({tag, "_all"}, 80'(dist_all[idx*20 +: 20]), 80'(exp_dist));
      step(1);
      check({tag, "_strobe"}, 80'(dist_valid), 80'd0);
   endtask

   task automatic serve(input string tag, input int exp_idx, input int n_us, input logic [19:0] exp_dist);
      int idx, waited, width;
      wait_trig(2000, idx, waited, width);
      check({tag, "_sel"}, 80'(idx), 80'(exp_idx));
      check({tag, "_trig_w"}, 80'(width), 80'(TRG * TD));
      pulse_and_check(tag, exp_idx, n_us, exp_dist);
   endtask

   task automatic do_reset(input logic [3:0] en);
      rst = 1'b0;
      echo = 4'b0000;
      step(3);
      enable = en;
      rst = 1'b1;
   endtask

   initial begin
      int idx, waited, width, edges;

      // Reset state
      step(3);
      check("rst_trig", 80'(trig), 80'd0);
      check("rst_busy", 80'(busy), 80'd0);
      check("rst_valid", 80'(dist_valid), 80'd0);
      check("rst_tmo", 80'(timeout), 80'd0);
      check("rst_dist", 80'(dist_out), 80'hFFFFF);
      check("rst_id", 80'(dist_id), 80'd0);
      check("rst_all", dist_all, {4{20'hFFFFF}});

      // No sensors enabled: stays idle
      rst = 1'b1;
      step(20);
      check("idle_busy", 80'(busy), 80'd0);
      check("idle_trig", 80'(trig), 80'd0);

      // Single sensor, 1000 us echo -> 17 cm
      enable = 4'b0001;
      serve("one", 0, 1000, 20'd17);

      // Round robin 0,1,3,0 with sensor 2 disabled
      do_reset(4'b1011);
      saw_trig2 = 1'b0;
      serve("rr0", 0, 2000, 20'd34);
      serve("rr1", 1, 3000, 20'd51);
      serve("rr3", 3, 4000, 20'd68);
      serve("rr0b", 0, 1000, 20'd17);
      check("rr_all", dist_all, {20'd68, 20'hFFFFF, 20'd51, 20'd17});

      // Reset while measuring sensor 1
      wait_trig(2000, idx, waited, width);
      check("rstm_sel", 80'(idx), 80'd1);
      step(3);
      echo[1] = 1'b1;
      step(50);
      check("rstm_busy_pre", 80'(busy), 80'd1);
      rst = 1'b0;
      step(1);
      check("rstm_trig", 80'(trig), 80'd0);
      check("rstm_busy", 80'(busy), 80'd0);
      check("rstm_all", dist_all, {4{20'hFFFFF}});
      check("rstm_valid", 80'(dist_valid), 80'd0);
      echo = 4'b0000;
      step(2);
      check("rstm_valid2", 80'(dist_valid), 80'd0);
      enable = 4'b0011;
      rst = 1'b1;
      wait_trig(100, idx, waited, width);
      check("rstm_first", 80'(idx), 80'd0);

      // Enable cleared mid-measurement: 500 us still reported as 8 cm
      step(3);
      echo[0] = 1'b1;
      step(10);
      enable = 4'b0000;
      step(500 * TD - 10);
      echo[0] = 1'b0;
      wait_valid(50, edges);
      check("dis_lat", 80'(edges), 80'd3);
      check("dis_dist", 80'(dist_out), 80'd8);
      check("dis_tmo", 80'(timeout), 80'd0);
      step(200);
      check("dis_busy", 80'(busy), 80'd0);
      check("dis_trig", 80'(trig), 80'd0);

      // Echo never rises: timeout after TRIG + TIMEOUT ticks
      do_reset(4'b0001);
      wait_trig(100, idx, waited, width);
      wait_valid(20000, edges);
      check("nr_lat", 80'(width + edges), 80'((TRG + TMO) * TD));
      check("nr_dist", 80'(dist_out), 80'hFFFFF);
      check("nr_tmo", 80'(timeout), 80'd1);
      check("nr_id", 80'(dist_id), 80'd0);
      enable = 4'b0011;
      wait_trig(200, idx, waited, width);
      check("nr_next_sel", 80'(idx), 80'd1);
      check("nr_gap", 80'(waited), 80'(GP * TD + 2));
      pulse_and_check("nr_next", 1, 100, 20'd1);

      // Echo held high: timeout when count reaches TIMEOUT
      do_reset(4'b0001);
      wait_trig(100, idx, waited, width);
      step(3);
      echo[0] = 1'b1;
      wait_valid(20000, edges);
      check("hh_lat", 80'(edges), 80'(TMO * TD + 4));
      check("hh_dist", 80'(dist_out), 80'hFFFFF);
      check("hh_tmo", 80'(timeout), 80'd1);
      echo = 4'b0000;

      check("no_trig2", 80'(saw_trig2), 80'd0);
      check("trig_onehot", 80'(saw_multi), 80'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sonic_scheduler.md
SONIC_SCHEDULER -- requirements
Module: sonic_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100: clk cycles per 1 us tick.
REQ-002 SHALL have parameter TRIG_US, default 10: trigger pulse width in ticks.
REQ-003 SHALL have parameter TIMEOUT_US, default 30000: echo wait/measure limit in ticks.
REQ-004 SHALL have parameter GAP_US, default 60000: settle time between measurements in ticks.
REQ-005 SHALL have port clk, input, 1: the only clock, 100 MHz.
REQ-006 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port enable, input, 4: per-sensor enable mask.
REQ-008 SHALL have port echo, input, 4: asynchronous sensor echo pins.
REQ-009 SHALL have port trig, output, 4: sensor trigger pins.
REQ-010 SHALL have port dist_out, output, 20: last result in cm.
REQ-011 SHALL have port dist_id, output, 2: sensor index of dist_out.
REQ-012 SHALL have port dist_valid, output, 1: one-cycle strobe for a new result.
REQ-013 SHALL have port timeout, output, 1: last result was a timeout.
REQ-014 SHALL have port dist_all, output, 80: per-sensor latest distance; sensor n occupies bits [20n+19:20n].
REQ-015 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-016 SHALL share one measurement engine among 4 sensors, measuring one sensor at a time.
REQ-017 SHALL pass each echo bit through a 2-flop synchronizer plus a history flop; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-018 SHALL ignore edges on every sensor except the selected one.
REQ-019 SHALL use a prescaler that pulses tick every TICK_DIV clks and clears to 0 on every state transition, so each state lasts an exact multiple of TICK_DIV cycles.
REQ-020 SHALL implement states IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, GAP.
REQ-021 SHALL, in IDLE with enable != 0, select the next enabled index after the last-served index (round robin, wrapping 3->0) and go to TRIG; with enable == 0 it SHALL stay in IDLE.
REQ-022 SHALL sample enable only in IDLE; mask changes mid-measurement SHALL NOT abort the current measurement.
REQ-023 SHALL, in TRIG, drive trig[sel]=1 for exactly TRIG_US*TICK_DIV clks, then go to WAIT_RISE; all other trig bits SHALL be 0 at all times.
REQ-024 SHALL, in WAIT_RISE, go to MEASURE with count=0 on rise; if TIMEOUT_US ticks elapse first it SHALL go to REPORT flagged timeout.
REQ-025 SHALL, in MEASURE, increment a 16-bit count on each tick and go to REPORT on fall; at count == TIMEOUT_US it SHALL go to REPORT flagged timeout.
REQ-026 SHALL compute the distance as count*17/1000 (integer, truncating) using a 20-bit-or-wider intermediate.
REQ-027 SHALL use 20'hFFFFF as the timeout distance.
REQ-028 SHALL, in REPORT (1 cycle): assert dist_valid=1; register dist_out, dist_id=sel and timeout; update dist_all[sel]; then go to GAP.
REQ-029 SHALL keep dist_out, dist_id, timeout and dist_all stable between REPORT cycles.
REQ-030 SHALL, in GAP, wait GAP_US ticks then go to IDLE.
REQ-031 SHALL assert dist_valid on the 3rd rising clk edge after echo falls at the pin (2 sync stages + 1 state register).
REQ-032 SHALL treat a rise and fall in the same cycle as "no edge"; this case is impossible after synchronization.
REQ-033 SHALL ignore an echo already high when entering WAIT_RISE until it falls and rises again.

Reset
REQ-034 SHALL, while rst == 0 at a clk edge: set state IDLE, trig=0, dist_valid=0, timeout=0, dist_out=20'hFFFFF, dist_id=0, every dist_all slot=20'hFFFFF, busy=0, last-served index=3 (first served = lowest enabled), synchronizers=0, prescaler=0, count=0.
REQ-035 SHALL abort any state on reset mid-operation, drop trig within the same edge, and produce no dist_valid.
REQ-036 SHALL make the far-distance reset values keep downstream consumers idle until real data arrives.

Verification
REQ-037 enable=4'b0001, echo[0] high 1000 us after trig -> trig[0] high 1000 clks; dist_valid with dist_out=17, dist_id=0, timeout=0, dist_all[19:0]=17.
REQ-038 enable=4'b1011, echo returns 2000/3000/4000 us -> service order 0,1,3,0; results 34, 51, 68; sensor 2 trig never asserted.
REQ-039 echo[0] never rises -> after 10+30000 us, dist_valid with dist_out=20'hFFFFF, timeout=1; next sensor served after GAP.
REQ-040 echo[0] held high >30000 us -> timeout at count=30000, dist_out=20'hFFFFF, timeout=1.
REQ-041 rst low during MEASURE -> trig=0, busy=0, dist_all all 20'hFFFFF next cycle, no dist_valid; after release, sensor 0 served first.
REQ-042 enable cleared to 0 during MEASURE -> current result still reported, then stays IDLE with busy=0.
